// File: rtl/frame_crc_insert_pkg.sv
// Shared definitions for the CRC-16 inserting stream stage: defaults, beat record
// and a byte-serial CRC-16 step (MSB-first, no reflection).
package frame_crc_insert_pkg;
  localparam logic [15:0] CRC_POLY_DEF = 16'h1021;
  localparam logic [15:0] CRC_INIT_DEF = 16'hFFFF;

  typedef struct packed {
    logic [3:0][7:0] data;  // data[3] is byte 0 (first on the wire)
    logic [2:0]      keep;
    logic            last;
  } beat_t;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b,
                                             input logic [15:0] poly);
    logic [15:0] c;
    c = crc ^ {b, 8'h00};
    for (int i = 0; i < 8; i++)
      c = c[15] ? ((c << 1) ^ poly) : (c << 1);
    return c;
  endfunction
endpackage

// File: rtl/frame_crc_insert_crc16_bytes.sv
// Combinational CRC-16 advance over the first cnt bytes of data (data[NB-1] first).
module crc16_bytes
  import frame_crc_insert_pkg::*;
#(
  parameter logic [15:0] POLY = CRC_POLY_DEF,
  parameter int          NB   = 4
) (
  input  logic [15:0]             crc_in,
  input  logic [NB-1:0][7:0]      data,
  input  logic [$clog2(NB+1)-1:0] cnt,
  output logic [15:0]             crc_out
);
  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < NB; i++)
      if (i < int'(cnt)) crc_out = crc16_byte(crc_out, data[NB-1-i], POLY);
  end
endmodule

// File: rtl/frame_crc_insert.sv
// Overwrites the last two bytes of each frame with CRC-16/CCITT-FALSE of the rest.
// Hold register H delays each beat until the next one reveals where the frame ends.
module frame_crc_insert
  import frame_crc_insert_pkg::*;
#(
  parameter logic [15:0] CRC_POLY = CRC_POLY_DEF,
  parameter logic [15:0] CRC_INIT = CRC_INIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_axis_tdata,
  input  logic [3:0]  s_axis_tkeep,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic [15:0] frame_cnt,
  output logic        err_pulse
);
  beat_t           h, o, h_nxt, o_nxt;
  logic            h_vld, o_vld, h_good, o_good;
  logic [15:0]     crc_r, crc_base, crc_adv;
  logic [1:0]      byte_cnt, pidx;
  logic            o_free, accept, h_move, pend_v, bad_keep, short_frm, patch;
  logic [2:0]      k, nb, n, total;
  logic [3:0][7:0] cvec;

  assign o_free        = m_axis_tready || !o_vld;
  assign s_axis_tready = !rst && o_free;
  assign accept        = s_axis_tready && s_axis_tvalid;
  assign h_move        = o_free && h_vld && (accept || h.last);
  // crc_r covers the frame up to, but not including, the last valid byte held in H
  assign pend_v        = h_vld && !h.last;
  assign pidx          = 2'(3'd4 - h.keep);

  assign bad_keep  = (s_axis_tkeep == 4'd0) || (s_axis_tkeep > 4'd4);
  assign k         = bad_keep ? 3'd4 : s_axis_tkeep[2:0];
  assign total     = {1'b0, byte_cnt} + k;
  assign short_frm = s_axis_tlast && (total < 3'd3);
  assign patch     = s_axis_tlast && !short_frm;

  // Bytes fed this beat: H's pending byte (unless it turns out to be a CRC slot),
  // then the new beat minus its last byte, or minus its two CRC slots on tlast.
  assign nb       = s_axis_tlast ? ((k >= 3'd2) ? k - 3'd2 : 3'd0) : k - 3'd1;
  assign n        = !pend_v ? nb : (s_axis_tlast && k == 3'd1) ? 3'd0 : nb + 3'd1;
  assign cvec     = pend_v ? {h.data[pidx], s_axis_tdata[31:8]} : s_axis_tdata;
  assign crc_base = pend_v ? crc_r : CRC_INIT;

  crc16_bytes #(.POLY(CRC_POLY), .NB(4)) u_crc (
    .crc_in (crc_base),
    .data   (cvec),
    .cnt    (n),
    .crc_out(crc_adv)
  );

  always_comb begin
    h_nxt.data = s_axis_tdata;
    h_nxt.keep = k;
    h_nxt.last = s_axis_tlast;
    if (patch)
      case (k)
        3'd1:    h_nxt.data[3]   = crc_adv[7:0];
        3'd2:    h_nxt.data[3:2] = crc_adv;
        3'd3:    h_nxt.data[2:1] = crc_adv;
        default: h_nxt.data[1:0] = crc_adv;
      endcase
    o_nxt = h;
    // one-byte tail: CRC high byte lands in the beat leaving H this cycle
    if (accept && patch && k == 3'd1) o_nxt.data[pidx] = crc_adv[15:8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h         <= '0;
      o         <= '0;
      h_vld     <= 1'b0;
      o_vld     <= 1'b0;
      h_good    <= 1'b0;
      o_good    <= 1'b0;
      crc_r     <= CRC_INIT;
      byte_cnt  <= 2'd0;
      frame_cnt <= 16'd0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= accept && (bad_keep || short_frm);
      if (o_vld && m_axis_tready && o.last && o_good) frame_cnt <= frame_cnt + 16'd1;
      if (h_move) begin
        o      <= o_nxt;
        o_good <= h_good;
        o_vld  <= 1'b1;
      end else if (m_axis_tready) begin
        o_vld  <= 1'b0;
      end
      if (accept) begin
        h        <= h_nxt;
        h_vld    <= 1'b1;
        h_good   <= patch;
        crc_r    <= s_axis_tlast ? CRC_INIT : crc_adv;
        byte_cnt <= s_axis_tlast ? 2'd0 : (total >= 3'd3) ? 2'd3 : total[1:0];
      end else if (h_move) begin
        h_vld    <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = o.data;
  assign m_axis_tkeep  = {1'b0, o.keep};
  assign m_axis_tvalid = o_vld;
  assign m_axis_tlast  = o.last;
endmodule

// File: tb/tb_frame_crc_insert.sv
// Bench for frame_crc_insert: directed vector table, hand sequences and random
// frames under backpressure against a byte-stream reference model.
module tb_frame_crc_insert;
  typedef struct packed { logic [31:0] d; logic [3:0] k; logic l; } beat_t;
  typedef struct { logic [31:0] d; logic [3:0] k; logic l; logic [31:0] ed; logic [3:0] ek; } vec_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] s_tdata = '0;
  logic [3:0]  s_tkeep = '0;
  logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tvalid, m_tlast, m_tready = 1'b1;
  logic [15:0] frame_cnt;
  logic        err_pulse;
  int          checks = 0, failures = 0, err_seen = 0, exp_err = 0, exp_frames = 0;
  beat_t       in_q[$], exp_q[$];

  always #5 clk = ~clk;

  frame_crc_insert dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .frame_cnt(frame_cnt), .err_pulse(err_pulse)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bitwise CRC-16/CCITT-FALSE over the first n bytes.
  function automatic logic [15:0] ref_crc(input logic [7:0] b[$], input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++)
      for (int j = 7; j >= 0; j--) begin
        fb = c[15] ^ b[i][j];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    return c;
  endfunction

  // Flatten the frame to bytes, overwrite the last two with the CRC, re-split.
  task automatic add_frame(input beat_t fb[$]);
    logic [7:0]  bytes[$];
    logic [15:0] c;
    beat_t       e;
    int          n, p;
    foreach (fb[i]) for (int s = 0; s < int'(fb[i].k); s++) bytes.push_back(fb[i].d[31-8*s -: 8]);
    n = bytes.size();
    if (n >= 3) begin
      c = ref_crc(bytes, n - 2);
      bytes[n-2] = c[15:8];
      bytes[n-1] = c[7:0];
      exp_frames++;
    end else exp_err++;
    p = 0;
    foreach (fb[i]) begin
      e = fb[i];
      for (int s = 0; s < int'(fb[i].k); s++) begin
        e.d[31-8*s -: 8] = bytes[p];
        p++;
      end
      in_q.push_back(fb[i]);
      exp_q.push_back(e);
    end
  endtask

  // Drive in_q, collect outputs against exp_q; starts and ends on a falling edge.
  task automatic run(input int rdy_pct);
    int    cyc;
    logic  stall;
    beat_t prev, got;
    cyc = 0; stall = 1'b0; prev = '0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < 20000) begin
      if (in_q.size() > 0) begin
        s_tvalid = 1'b1;
        {s_tdata, s_tkeep, s_tlast} = in_q[0];
      end else s_tvalid = 1'b0;
      m_tready = ($urandom_range(99) < rdy_pct);
      #1;
      got = {m_tdata, m_tkeep, m_tlast};
      if (stall) begin
        chk("stall_valid", 64'(m_tvalid), 64'(1));
        chk("stall_hold", 64'(got), 64'(prev));
      end
      if (err_pulse) err_seen++;
      if (s_tvalid && s_tready) void'(in_q.pop_front());
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL extra_beat: got %h expected none", got);
        end else chk("beat", 64'(got), 64'(exp_q.pop_front()));
      end
      stall = m_tvalid && !m_tready;
      prev  = got;
      cyc++;
      @(negedge clk);
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    if (cyc >= 20000) begin
      checks++; failures++;
      $display("FAIL timeout: %0d beats left expected 0", exp_q.size());
      in_q.delete(); exp_q.delete();
    end
    repeat (2) begin
      #1;
      if (err_pulse) err_seen++;
      @(negedge clk);
    end
  endtask

  vec_t  tab[10];
  beat_t fb[$];
  beat_t b;
  int    n, fc0, es0;

  initial begin
    tab[0] = '{32'h31323334, 4'd4, 1'b0, 32'h31323334, 4'd4};
    tab[1] = '{32'h35363738, 4'd4, 1'b0, 32'h35363738, 4'd4};
    tab[2] = '{32'h39000000, 4'd3, 1'b1, 32'h3929B100, 4'd3};
    tab[3] = '{32'h31323334, 4'd4, 1'b0, 32'h31323334, 4'd4};
    tab[4] = '{32'h35363738, 4'd4, 1'b0, 32'h35363738, 4'd4};
    tab[5] = '{32'h39000000, 4'd2, 1'b0, 32'h39290000, 4'd2};
    tab[6] = '{32'h00000000, 4'd1, 1'b1, 32'hB1000000, 4'd1};
    tab[7] = '{32'h31323334, 4'd4, 1'b0, 32'h31323334, 4'd4};
    tab[8] = '{32'h35363738, 4'd0, 1'b0, 32'h35363738, 4'd4};
    tab[9] = '{32'h39000000, 4'd3, 1'b1, 32'h3929B100, 4'd3};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_s_tready", 64'(s_tready), 64'(0));
    chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_m_tdata", 64'(m_tdata), 64'(0));
    chk("rst_m_tkeep", 64'(m_tkeep), 64'(0));
    chk("rst_m_tlast", 64'(m_tlast), 64'(0));
    chk("rst_frame_cnt", 64'(frame_cnt), 64'(0));
    chk("rst_err", 64'(err_pulse), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // directed table: known-CRC frames, split placeholders, out-of-range keep
    for (int i = 0; i < 10; i++) begin
      in_q.push_back({tab[i].d, tab[i].k, tab[i].l});
      exp_q.push_back({tab[i].ed, tab[i].ek, tab[i].l});
    end
    run(100);
    chk("tab_frame_cnt", 64'(frame_cnt), 64'(3));
    chk("tab_err_cnt", 64'(err_seen), 64'(1));
    exp_frames = 3; exp_err = 1;

    // placeholders split 4,4,4,1: CRC high byte in byte[7:0] of the penultimate beat
    fb.delete();
    fb.push_back({32'h31323334, 4'd4, 1'b0});
    fb.push_back({32'h35363738, 4'd4, 1'b0});
    fb.push_back({32'h39000000, 4'd4, 1'b0});
    fb.push_back({32'h00000000, 4'd1, 1'b1});
    add_frame(fb);
    run(100);
    chk("split_frame_cnt", 64'(frame_cnt), 64'(exp_frames));

    // two-byte frame: passthrough, one error pulse, counter untouched
    fc0 = int'(frame_cnt); es0 = err_seen;
    fb.delete();
    fb.push_back({32'h41420000, 4'd2, 1'b1});
    add_frame(fb);
    run(100);
    chk("short_frame_cnt", 64'(frame_cnt), 64'(fc0));
    chk("short_err_once", 64'(err_seen - es0), 64'(1));

    // 100 random back-to-back frames under ~50% backpressure
    for (int f = 0; f < 100; f++) begin
      fb.delete();
      n = ($urandom_range(9) == 0) ? int'($urandom_range(2, 1)) : int'($urandom_range(22, 3));
      while (n > 0) begin
        b.d = $urandom;
        b.k = (n >= 4) ? 4'd4 : 4'(n);
        n   = n - int'(b.k);
        b.l = (n == 0);
        fb.push_back(b);
      end
      add_frame(fb);
    end
    run(50);
    chk("rand_frame_cnt", 64'(frame_cnt), 64'(16'(exp_frames)));
    chk("rand_err_cnt", 64'(err_seen), 64'(exp_err));

    // reset with a partial frame sitting in the hold register
    s_tvalid = 1'b1;
    {s_tdata, s_tkeep, s_tlast} = {32'hDEADBEEF, 4'd4, 1'b0};
    #1 chk("midrst_accept", 64'(s_tready), 64'(1));
    @(negedge clk);
    s_tvalid = 1'b0;
    #1 chk("midrst_no_out", 64'(m_tvalid), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_s_tready", 64'(s_tready), 64'(0));
    chk("midrst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("midrst_frame_cnt", 64'(frame_cnt), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    exp_frames = 0; exp_err = 0; err_seen = 0;
    fb.delete();
    fb.push_back({32'h31323334, 4'd4, 1'b0});
    fb.push_back({32'h35363738, 4'd4, 1'b0});
    fb.push_back({32'h39000000, 4'd3, 1'b1});
    add_frame(fb);
    run(100);
    chk("fresh_frame_cnt", 64'(frame_cnt), 64'(1));
    chk("fresh_err_cnt", 64'(err_seen), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
